// File: rtl/mmac_pkg.sv
`default_nettype none
// ============================================================================
// mmac_pkg -- shared defaults, FSM state type and saturation helper for mmac
// Rev 1.0
// ============================================================================
package mmac_pkg;

  localparam int MMAC_N     = 4;
  localparam int MMAC_W     = 8;
  localparam int MMAC_ACC_W = 18;

  // Widest accumulator the saturation helper can handle (ACC_W + 1 must fit).
  localparam int SAT_MAX_W  = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_B = 2'd1,
    MAC_A  = 2'd2,
    DRAIN  = 2'd3
  } mmac_state_e;

  typedef struct packed {
    logic [SAT_MAX_W-1:0] val;
    logic                 ovf;
  } sat_res_t;

  // value holds an (acc_w+1)-bit sum, zero-extended. Clamps it to the acc_w
  // range of the active mode; the sum never exceeds acc_w+1 bits.
  function automatic sat_res_t acc_sat(input logic [SAT_MAX_W-1:0] value,
                                       input logic                 signed_mode,
                                       input int unsigned          acc_w);
    logic [SAT_MAX_W-1:0] one;
    logic [SAT_MAX_W-1:0] mask;
    logic [SAT_MAX_W-1:0] smin;
    logic                 msb;
    logic                 nxt;
    sat_res_t             res;
    one   = {{(SAT_MAX_W-1){1'b0}}, 1'b1};
    mask  = (one << acc_w) - one;
    smin  = one << (acc_w - 1);
    msb   = |(value & (one << acc_w));
    nxt   = |(value & smin);
    res.val = value & mask;
    res.ovf = 1'b0;
    if (signed_mode) begin
      if (msb != nxt) begin
        res.ovf = 1'b1;
        res.val = msb ? smin : (smin - one);
      end
    end else if (msb) begin
      res.ovf = 1'b1;
      res.val = mask;
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mmac_dot.sv
`default_nettype none
// ============================================================================
// mmac_dot -- combinational N-element dot product, signed/unsigned selectable
// Rev 1.0
// ============================================================================
module mmac_dot
  import mmac_pkg::*;
#(
  parameter int N = MMAC_N,
  parameter int W = MMAC_W
) (
  input  logic [N*W-1:0]            a_row,
  input  logic [N*W-1:0]            b_col,
  input  logic                      signed_mode,
  output logic [2*W+$clog2(N)-1:0]  dot
);

  localparam int SUM_W = 2*W + $clog2(N);
  localparam int PW    = 2*W + 2;
  localparam int XW    = PW + $clog2(N);

  logic signed [PW-1:0] prod [N];
  logic signed [XW-1:0] acc;
  logic                 unused_acc_hi;

  // One extra operand bit lets a single signed multiplier serve both modes.
  for (genvar k = 0; k < N; k++) begin : g_mul
    logic signed [W:0] a_x;
    logic signed [W:0] b_x;
    assign a_x     = {signed_mode & a_row[k*W+W-1], a_row[k*W +: W]};
    assign b_x     = {signed_mode & b_col[k*W+W-1], b_col[k*W +: W]};
    assign prod[k] = a_x * b_x;
  end

  always_comb begin
    acc = '0;
    for (int k = 0; k < N; k++) begin
      acc = acc + {{(XW-PW){prod[k][PW-1]}}, prod[k]};
    end
  end

  assign dot           = acc[SUM_W-1:0];
  assign unused_acc_hi = ^acc[XW-1:SUM_W];

endmodule
`default_nettype wire

// File: rtl/mmac_tile_acc.sv
`default_nettype none
// ============================================================================
// mmac_tile_acc -- N x N tile computing C += A*B over valid/ready row streams
// Rev 1.0
// ============================================================================
module mmac_tile_acc
  import mmac_pkg::*;
#(
  parameter int N     = MMAC_N,
  parameter int W     = MMAC_W,
  parameter int ACC_W = MMAC_ACC_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic               start_clr,
  input  logic               start_emit,
  input  logic               start_signed,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*W-1:0]     in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N*ACC_W-1:0] out_data,
  output logic               out_last,
  output logic               ovf,
  output logic               busy
);

  localparam int            RW       = $clog2(N);
  localparam int            SUM_W    = 2*W + $clog2(N);
  localparam logic [RW-1:0] LAST_ROW = RW'(N-1);

  mmac_state_e   state_q, state_d;
  logic [RW-1:0] row_cnt_q, row_cnt_d;
  logic          emit_q, emit_d;
  logic          signed_q, signed_d;
  logic          ovf_q, ovf_d;
  logic [W-1:0]     b_q [N][N];
  logic [W-1:0]     b_d [N][N];
  logic [ACC_W-1:0] c_q [N][N];
  logic [ACC_W-1:0] c_d [N][N];

  logic [N*W-1:0]   b_col   [N];
  logic [ACC_W-1:0] sat_val [N];
  logic [N-1:0]     sat_ovf;
  logic [N-1:0]     unused_sat_hi;
  logic             row_last;

  assign row_last    = (row_cnt_q == LAST_ROW);
  assign start_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign in_ready    = (state_q == LOAD_B) || (state_q == MAC_A);
  assign out_valid   = (state_q == DRAIN);
  assign out_last    = (state_q == DRAIN) && row_last;
  assign ovf         = ovf_q;

  always_comb begin
    out_data = '0;
    if (state_q == DRAIN) begin
      for (int j = 0; j < N; j++) begin
        out_data[j*ACC_W +: ACC_W] = c_q[row_cnt_q][j];
      end
    end
  end

  // B is stored row-major as loaded; each dot unit needs one column of it.
  always_comb begin
    b_col = '{default: '0};
    for (int j = 0; j < N; j++) begin
      for (int k = 0; k < N; k++) begin
        b_col[j][k*W +: W] = b_q[k][j];
      end
    end
  end

  for (genvar j = 0; j < N; j++) begin : g_col
    logic [SUM_W-1:0] dot;
    logic [ACC_W-1:0] c_old;
    logic [ACC_W:0]   sum;
    sat_res_t         res;

    mmac_dot #(
      .N (N),
      .W (W)
    ) u_dot (
      .a_row       (in_data),
      .b_col       (b_col[j]),
      .signed_mode (signed_q),
      .dot         (dot)
    );

    assign c_old = c_q[row_cnt_q][j];
    assign sum   = {signed_q & c_old[ACC_W-1], c_old}
                 + {{(ACC_W+1-SUM_W){signed_q & dot[SUM_W-1]}}, dot};
    assign res   = acc_sat({{(SAT_MAX_W-ACC_W-1){1'b0}}, sum}, signed_q, ACC_W);

    assign sat_val[j]       = res.val[ACC_W-1:0];
    assign sat_ovf[j]       = res.ovf;
    assign unused_sat_hi[j] = ^res.val[SAT_MAX_W-1:ACC_W];
  end

  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    emit_d    = emit_q;
    signed_d  = signed_q;
    ovf_d     = ovf_q;
    b_d       = b_q;
    c_d       = c_q;

    case (state_q)
      IDLE: begin
        if (start_valid) begin
          emit_d    = start_emit;
          signed_d  = start_signed;
          row_cnt_d = '0;
          state_d   = LOAD_B;
          if (start_clr) begin
            c_d   = '{default: '0};
            ovf_d = 1'b0;
          end
        end
      end

      LOAD_B: begin
        if (in_valid) begin
          for (int j = 0; j < N; j++) begin
            b_d[row_cnt_q][j] = in_data[j*W +: W];
          end
          if (row_last) begin
            row_cnt_d = '0;
            state_d   = MAC_A;
          end else begin
            row_cnt_d = row_cnt_q + 1'b1;
          end
        end
      end

      MAC_A: begin
        if (in_valid) begin
          for (int j = 0; j < N; j++) begin
            c_d[row_cnt_q][j] = sat_val[j];
          end
          ovf_d = ovf_q | (|sat_ovf);
          if (row_last) begin
            row_cnt_d = '0;
            state_d   = emit_q ? DRAIN : IDLE;
          end else begin
            row_cnt_d = row_cnt_q + 1'b1;
          end
        end
      end

      DRAIN: begin
        if (out_ready) begin
          if (row_last) begin
            row_cnt_d = '0;
            state_d   = IDLE;
          end else begin
            row_cnt_d = row_cnt_q + 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      row_cnt_q <= '0;
      emit_q    <= 1'b0;
      signed_q  <= 1'b0;
      ovf_q     <= 1'b0;
      b_q       <= '{default: '0};
      c_q       <= '{default: '0};
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      emit_q    <= emit_d;
      signed_q  <= signed_d;
      ovf_q     <= ovf_d;
      b_q       <= b_d;
      c_q       <= c_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mmac_tile_acc.sv
`default_nettype none
// ============================================================================
// tb_mmac_tile_acc -- vector table + scoreboard bench for mmac_tile_acc (4x4, 8b, 18b acc)
// Rev 1.0
// ============================================================================
module tb_mmac_tile_acc;

  localparam int N     = 4;
  localparam int W     = 8;
  localparam int ACC_W = 18;

  logic               clk;
  logic               rst;
  logic               start_valid;
  logic               start_ready;
  logic               start_clr;
  logic               start_emit;
  logic               start_signed;
  logic               in_valid;
  logic               in_ready;
  logic [N*W-1:0]     in_data;
  logic               out_valid;
  logic               out_ready;
  logic [N*ACC_W-1:0] out_data;
  logic               out_last;
  logic               ovf;
  logic               busy;

  mmac_tile_acc #(
    .N     (N),
    .W     (W),
    .ACC_W (ACC_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .start_clr    (start_clr),
    .start_emit   (start_emit),
    .start_signed (start_signed),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .ovf          (ovf),
    .busy         (busy)
  );

  typedef struct {
    logic        clr;
    logic        sgn;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [17:0] exp;
    logic        exp_ovf;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          ready_mode = 0;
  logic [7:0]  mat_a [4][4];
  logic [7:0]  mat_b [4][4];
  logic [17:0] mc [4][4];
  logic        model_ovf;
  logic [72:0] exp_q [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk(name, 128'({start_ready, busy, in_ready, out_valid, out_last, ovf, out_data}),
              128'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 72'd0}));
  endtask

  function automatic longint opv(input logic [7:0] x, input logic sgn);
    return sgn ? longint'($signed(x)) : longint'(x);
  endfunction

  // Reference: exact integer dot product, then clamp to the 18-bit mode range.
  function automatic void model_row(input int i, input logic sgn);
    for (int j = 0; j < 4; j++) begin
      longint dot;
      longint c;
      dot = 0;
      for (int k = 0; k < 4; k++) dot += opv(mat_a[i][k], sgn) * opv(mat_b[k][j], sgn);
      c = sgn ? longint'($signed(mc[i][j])) : longint'(mc[i][j]);
      c += dot;
      if (sgn && c > 131071) begin c = 131071; model_ovf = 1'b1; end
      else if (sgn && c < -131072) begin c = -131072; model_ovf = 1'b1; end
      else if (!sgn && c > 262143) begin c = 262143; model_ovf = 1'b1; end
      mc[i][j] = c[17:0];
    end
  endfunction

  function automatic logic [31:0] pack_a(input int i);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[k*8 +: 8] = mat_a[i][k];
    return r;
  endfunction

  function automatic logic [31:0] pack_b(input int i);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[k*8 +: 8] = mat_b[i][k];
    return r;
  endfunction

  function automatic logic [71:0] model_out_row(input int i);
    logic [71:0] r;
    for (int j = 0; j < 4; j++) r[j*18 +: 18] = mc[i][j];
    return r;
  endfunction

  // out_ready policy: 0 = always ready, 1 = random, 2 = stalled
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Scoreboard consumer: pops one expected row per output handshake.
  initial begin : monitor
    logic        held;
    logic [71:0] hd;
    logic        hl;
    logic [72:0] e;
    held = 1'b0;
    hd   = '0;
    hl   = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && out_valid) begin
        if (held) chk("hold_stable", 128'({out_data, out_last}), 128'({hd, hl}));
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_row: got %0h, expected no output", out_data);
          end else begin
            e = exp_q.pop_front();
            chk("row_data", 128'(out_data), 128'(e[72:1]));
            chk("row_last", 128'(out_last), 128'(e[0]));
          end
          held = 1'b0;
        end else begin
          held = 1'b1;
          hd   = out_data;
          hl   = out_last;
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  task automatic feed_beat(input logic [31:0] d, input bit gaps);
    int   cnt;
    logic acc;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        in_data  = $urandom();
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b1;
    in_data  = d;
    cnt      = 0;
    forever begin
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      cnt++;
      if (cnt > 50) begin
        fail_now("beat_accept_timeout");
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic start_job(input logic clr, input logic emit, input logic sgn);
    chk("start_ready_idle", 128'(start_ready), 128'(1'b1));
    start_valid  = 1'b1;
    start_clr    = clr;
    start_emit   = emit;
    start_signed = sgn;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    if (clr) begin
      mc        = '{default: '0};
      model_ovf = 1'b0;
    end
    chk("start_busy", 128'({busy, start_ready}), 128'(2'b10));
  endtask

  task automatic run_job(input logic clr, input logic emit, input logic sgn, input bit gaps,
                         input bit use_const, input logic [17:0] cexp, input logic covf);
    int          cnt;
    logic [71:0] row;
    start_job(clr, emit, sgn);
    for (int r = 0; r < 4; r++) feed_beat(pack_b(r), gaps);
    for (int i = 0; i < 4; i++) begin
      feed_beat(pack_a(i), gaps);
      model_row(i, sgn);
    end
    if (emit) begin
      for (int i = 0; i < 4; i++) begin
        for (int j = 0; j < 4; j++) row[j*18 +: 18] = use_const ? cexp : mc[i][j];
        exp_q.push_back({row, (i == 3)});
      end
      chk("drain_entry", 128'(out_valid), 128'(1'b1));
    end else begin
      chk("busy_after_a", 128'({busy, out_valid}), 128'(2'b00));
    end
    cnt = 0;
    while (busy && cnt < 200) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    if (busy) fail_now("job_timeout");
    chk("idle_start_ready", 128'(start_ready), 128'(1'b1));
    chk("ovf_after_job", 128'(ovf), 128'(use_const ? covf : model_ovf));
    chk("queue_empty", 128'(exp_q.size()), 128'(0));
  endtask

  task automatic set_identity_case();
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 4; k++) begin
        mat_a[i][k] = 8'(i*4 + k + 1);
        mat_b[i][k] = (i == k) ? 8'd1 : 8'd0;
      end
    end
  endtask

  initial begin
    vec_t        tbl [11];
    logic        rc;
    logic        rs;
    logic [71:0] row0;

    // clr, signed, a, b, expected element, expected ovf
    tbl[0]  = '{1'b1, 1'b0, 8'hFF, 8'hFF, 18'd260100, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 8'hFF, 8'hFF, 18'd4,      1'b0};
    tbl[2]  = '{1'b1, 1'b1, 8'h7F, 8'h7F, 18'd64516,  1'b0};
    tbl[3]  = '{1'b0, 1'b1, 8'h7F, 8'h7F, 18'd129032, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 8'h7F, 8'h7F, 18'd131071, 1'b1};
    tbl[5]  = '{1'b1, 1'b1, 8'h01, 8'h01, 18'd4,      1'b0};
    tbl[6]  = '{1'b1, 1'b1, 8'h80, 8'h7F, 18'd197120, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 8'h80, 8'h7F, 18'd132096, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 8'h80, 8'h7F, 18'd131072, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 8'hFF, 8'hFF, 18'd260100, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 8'hFF, 8'hFF, 18'd262143, 1'b1};

    rst          = 1'b1;
    start_valid  = 1'b0;
    start_clr    = 1'b0;
    start_emit   = 1'b0;
    start_signed = 1'b0;
    in_valid     = 1'b0;
    in_data      = '0;
    mc           = '{default: '0};
    model_ovf    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset_state");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // B = I: C follows A, then doubles without clr, then a silent clr job
    set_identity_case();
    run_job(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    run_job(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    run_job(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);

    for (int t = 0; t < 11; t++) begin
      for (int i = 0; i < 4; i++) begin
        for (int k = 0; k < 4; k++) begin
          mat_a[i][k] = tbl[t].a;
          mat_b[i][k] = tbl[t].b;
        end
      end
      run_job(tbl[t].clr, 1'b1, tbl[t].sgn, 1'b0, 1'b1, tbl[t].exp, tbl[t].exp_ovf);
    end

    // Random data, input gaps and output backpressure
    ready_mode = 1;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 4; i++) begin
        for (int k = 0; k < 4; k++) begin
          mat_a[i][k] = 8'($urandom_range(0, 255));
          mat_b[i][k] = 8'($urandom_range(0, 255));
        end
      end
      rc = (r == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      run_job(rc, 1'b1, rs, 1'b1, 1'b0, '0, 1'b0);
    end
    ready_mode = 0;
    @(posedge clk);
    #1;

    // Reset in the middle of the A phase
    set_identity_case();
    start_job(1'b0, 1'b1, 1'b1);
    for (int r = 0; r < 4; r++) feed_beat(pack_b(r), 1'b0);
    feed_beat(pack_a(0), 1'b0);
    feed_beat(pack_a(1), 1'b0);
    rst = 1'b1;
    #1;
    chk_reset_outputs("rst_mid_mac");
    @(posedge clk);
    #1;
    rst       = 1'b0;
    mc        = '{default: '0};
    model_ovf = 1'b0;

    // Reset while a drain is stalled
    ready_mode = 2;
    @(posedge clk);
    #1;
    start_job(1'b1, 1'b1, 1'b1);
    for (int r = 0; r < 4; r++) feed_beat(pack_b(r), 1'b0);
    for (int i = 0; i < 4; i++) begin
      feed_beat(pack_a(i), 1'b0);
      model_row(i, 1'b1);
    end
    repeat (2) @(posedge clk);
    #1;
    row0 = model_out_row(0);
    chk("drain_stall_row0", 128'({out_valid, out_last, out_data}), 128'({1'b1, 1'b0, row0}));
    rst = 1'b1;
    #1;
    chk_reset_outputs("rst_mid_drain");
    @(posedge clk);
    #1;
    rst        = 1'b0;
    mc         = '{default: '0};
    model_ovf  = 1'b0;
    ready_mode = 0;
    @(posedge clk);
    #1;

    // clr=0 after reset must accumulate from zero
    run_job(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
